// File: rtl/arm_ctrl_pkg.sv
// arm_ctrl_pkg: shared state, select, opcode and condition-code definitions for the multicycle ARM controller
package arm_ctrl_pkg;
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11;
    localparam logic [1:0] SRCA_RD1 = 2'b00, SRCA_PC = 2'b01;
    localparam logic [1:0] SRCB_RD2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURES = 2'b10;
    localparam logic [1:0] IMM_DP = 2'b00, IMM_MEM = 2'b01, IMM_BR = 2'b10;
    localparam logic [1:0] OP_DP = 2'b00, OP_MEM = 2'b01, OP_BR = 2'b10, OP_NOP = 2'b11;

    localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb;
    localparam logic [3:0] COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf;

    typedef struct packed {
        logic       next_pc;
        logic       ir_write;
        logic       mem_w;
        logic       reg_w;
        logic       branch;
        logic       alu_op;
        logic       adr_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] result_src;
    } ctrl_t;

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            COND_EQ: return z;
            COND_NE: return ~z;
            COND_CS: return c;
            COND_CC: return ~c;
            COND_MI: return n;
            COND_PL: return ~n;
            COND_VS: return v;
            COND_VC: return ~v;
            COND_HI: return c & ~z;
            COND_LS: return ~c | z;
            COND_GE: return n == v;
            COND_LT: return n != v;
            COND_GT: return ~z & (n == v);
            COND_LE: return z | (n != v);
            default: return 1'b1;
        endcase
    endfunction
endpackage

// File: rtl/arm_multicycle_controller_cond.sv
// arm_cond_unit: NZCV flag register and per-instruction condition latch gating architectural writes
module arm_cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       FlagUpdEn,
    input  logic       CondLatch,
    output logic       CondExReg
);
    logic [3:0] flags;
    logic       cond_ex;

    assign cond_ex = cond_holds(Cond, flags);

    always_ff @(posedge clk) begin
        if (reset) begin
            flags     <= 4'b0000;
            CondExReg <= 1'b0;
        end else begin
            if (CondLatch) CondExReg <= cond_ex;
            if (FlagUpdEn && CondExReg && FlagW[1]) flags[3:2] <= ALUFlags[3:2];
            if (FlagUpdEn && CondExReg && FlagW[0]) flags[1:0] <= ALUFlags[1:0];
        end
    end
endmodule

// File: rtl/arm_multicycle_controller.sv
// arm_multicycle_controller: Moore FSM plus field decode sequencing the shared-ALU multicycle ARM datapath
module arm_multicycle_controller
    import arm_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         Cond,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic [3:0]         Rd,
    input  logic [3:0]         ALUFlags,
    output logic               PCWrite,
    output logic               IRWrite,
    output logic               MemWrite,
    output logic               RegWrite,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         RegSrc,
    output logic [1:0]         ALUControl,
    output logic [STATE_W-1:0] state
);
    state_t     st, nxt;
    ctrl_t      ctl;
    logic [3:0] cmd;
    logic [1:0] dp_ctl, flag_w;
    logic       no_write, cv_cmd, reg_w, cond_ex_reg;

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.next_pc    = 1'b1;
                c.ir_write   = 1'b1;
                c.src_a      = SRCA_PC;
                c.src_b      = SRCB_FOUR;
                c.result_src = RES_ALURES;
            end
            DECODE: begin
                c.src_a      = SRCA_PC;
                c.src_b      = SRCB_FOUR;
                c.result_src = RES_ALURES;
            end
            MEMADR:   c.src_b = SRCB_IMM;
            MEMREAD:  c.adr_src = 1'b1;
            MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_w      = 1'b1;
            end
            MEMWRITE: begin
                c.adr_src = 1'b1;
                c.mem_w   = 1'b1;
            end
            EXECUTER: c.alu_op = 1'b1;
            EXECUTEI: begin
                c.alu_op = 1'b1;
                c.src_b  = SRCB_IMM;
            end
            ALUWB:    c.reg_w = 1'b1;
            BRANCH: begin
                c.src_b      = SRCB_IMM;
                c.result_src = RES_ALURES;
                c.branch     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        case (st)
            FETCH:              nxt = DECODE;
            DECODE:             nxt = Op == OP_MEM ? MEMADR : Op == OP_BR ? BRANCH :
                                      Op == OP_NOP ? FETCH : Funct[5] ? EXECUTEI : EXECUTER;
            MEMADR:             nxt = Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:            nxt = MEMWB;
            EXECUTER, EXECUTEI: nxt = ALUWB;
            default:            nxt = FETCH;
        endcase
    end

    // Select/enable bits are registered alongside the state they belong to
    always_ff @(posedge clk) begin
        if (reset) begin
            st  <= FETCH;
            ctl <= ctrl_of(FETCH);
        end else begin
            st  <= nxt;
            ctl <= ctrl_of(nxt);
        end
    end

    assign cmd = Funct[4:1];

    always_comb begin
        dp_ctl   = (cmd == 4'b0010 || cmd == 4'b1010) ? ALU_SUB :
                   cmd == 4'b0000 ? ALU_AND : cmd == 4'b1100 ? ALU_ORR : ALU_ADD;
        no_write = !(cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100});
        cv_cmd   = cmd inside {4'b0100, 4'b0010, 4'b1010};
        flag_w   = ctl.alu_op ? {Funct[0], Funct[0] & cv_cmd} : 2'b00;
        reg_w    = ctl.reg_w & ~((st == ALUWB) & no_write);
    end

    arm_cond_unit u_cond (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (flag_w),
        .FlagUpdEn(ctl.alu_op),
        .CondLatch(st == DECODE),
        .CondExReg(cond_ex_reg)
    );

    assign ALUControl = ctl.alu_op ? dp_ctl : ALU_ADD;
    assign ImmSrc     = Op == OP_MEM ? IMM_MEM : Op == OP_BR ? IMM_BR : IMM_DP;
    assign RegSrc     = {Op == OP_MEM & ~Funct[0], Op == OP_BR};
    assign RegWrite   = ~reset & reg_w & cond_ex_reg;
    assign MemWrite   = ~reset & ctl.mem_w & cond_ex_reg;
    assign PCWrite    = ~reset & (ctl.next_pc | ((ctl.branch | (reg_w & Rd == 4'd15)) & cond_ex_reg));
    assign IRWrite    = ~reset & ctl.ir_write;
    assign AdrSrc     = ctl.adr_src;
    assign ALUSrcA    = ctl.src_a;
    assign ALUSrcB    = ctl.src_b;
    assign ResultSrc  = ctl.result_src;
    assign state      = STATE_W'(st);
endmodule

// File: tb/tb_arm_multicycle_controller.sv
// tb_arm_multicycle_controller: table-driven and randomized checks of the controller against an instruction-level model
module tb_arm_multicycle_controller;
    import arm_ctrl_pkg::*;

    logic       clk = 1'b0, reset = 1'b1;
    logic [3:0] Cond = 4'h0, Rd = 4'h0, ALUFlags = 4'h0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0] state;

    int         vectors = 0, miscompares = 0;
    logic [3:0] mflags = 4'h0;

    always #5 clk = ~clk;

    arm_multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .state(state)
    );

    typedef struct {
        string      name;
        logic [3:0] cc;
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;
        logic [3:0] af;
        int         cyc;
        logic [3:0] fl;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Conditions come in complementary pairs: odd codes invert the even code's test
    function automatic logic cond_model(input logic [3:0] cc, input logic [3:0] fl);
        logic r;
        case (cc[3:1])
            3'd0: r = fl[2];
            3'd1: r = fl[1];
            3'd2: r = fl[3];
            3'd3: r = fl[0];
            3'd4: r = fl[1] & ~fl[2];
            3'd5: r = fl[3] == fl[0];
            3'd6: r = ~fl[2] & (fl[3] == fl[0]);
            default: return 1'b1;
        endcase
        return r ^ cc[0];
    endfunction

    function automatic logic [1:0] alu_model(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    function automatic bit writes_model(input logic [3:0] cmd);
        return cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 || cmd == 4'b1100;
    endfunction

    function automatic logic [31:0] got_vec();
        return {11'b0, state, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};
    endfunction

    function automatic logic [31:0] expect_cycle(input state_t s, input logic cex, input logic [1:0] op,
                                                 input logic [5:0] f, input logic [3:0] rd);
        logic pcw, irw, mw, rw, adr;
        logic [1:0] a, b, res, alu, imm, rs;
        {pcw, irw, mw, rw, adr} = 5'b0;
        {a, b, res, alu} = 8'b0;
        case (s)
            FETCH:    begin pcw = 1; irw = 1; a = 2'b01; b = 2'b10; res = 2'b10; end
            DECODE:   begin a = 2'b01; b = 2'b10; res = 2'b10; end
            MEMADR:   b = 2'b01;
            MEMREAD:  adr = 1;
            MEMWB:    begin res = 2'b01; rw = cex; pcw = cex && rd == 4'd15; end
            MEMWRITE: begin adr = 1; mw = cex; end
            EXECUTER: alu = alu_model(f[4:1]);
            EXECUTEI: begin b = 2'b01; alu = alu_model(f[4:1]); end
            ALUWB:    begin rw = cex && writes_model(f[4:1]); pcw = rw && rd == 4'd15; end
            BRANCH:   begin b = 2'b01; res = 2'b10; pcw = cex; end
            default: ;
        endcase
        imm = op == 2'b01 ? 2'b01 : op == 2'b10 ? 2'b10 : 2'b00;
        rs  = {op == 2'b01 && !f[0], op == 2'b10};
        return {11'b0, 4'(s), pcw, irw, mw, rw, adr, a, b, res, imm, rs, alu};
    endfunction

    // Starts one cycle into FETCH (just past a rising edge) and ends just past the edge back into FETCH
    task automatic run_instr(input string name, input logic [3:0] cc, input logic [1:0] op,
                             input logic [5:0] f, input logic [3:0] rd, input logic [3:0] af,
                             output int ncyc, output int plen);
        state_t path[$];
        logic   cex;
        int     n;
        cex = cond_model(cc, mflags);
        Cond = cc; Op = op; Funct = f; Rd = rd; ALUFlags = af;
        path = {FETCH, DECODE};
        case (op)
            2'b00: begin path.push_back(f[5] ? EXECUTEI : EXECUTER); path.push_back(ALUWB); end
            2'b01: begin
                path.push_back(MEMADR);
                path.push_back(f[0] ? MEMREAD : MEMWRITE);
                if (f[0]) path.push_back(MEMWB);
            end
            2'b10: path.push_back(BRANCH);
            default: ;
        endcase
        n = 0;
        do begin
            @(negedge clk);
            check($sformatf("%s cycle%0d", name, n), got_vec(),
                  expect_cycle(n < path.size() ? path[n] : FETCH, cex, op, f, rd));
            @(posedge clk);
            #1;
            n++;
        end while (state != 4'(FETCH) && n < 8);
        ncyc = n;
        plen = path.size();
        if (cex && op == 2'b00 && f[0]) begin
            mflags[3:2] = af[3:2];
            if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010 || f[4:1] == 4'b1010) mflags[1:0] = af[1:0];
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ncyc, plen;
        logic [1:0] op;
        logic [5:0] f;
        logic [3:0] rd;

        tbl[0]  = '{"add",     4'he, 2'b00, 6'b001000, 4'd1,  4'h0, 4, 4'h0};
        tbl[1]  = '{"ldr",     4'he, 2'b01, 6'b011001, 4'd2,  4'h0, 5, 4'h0};
        tbl[2]  = '{"str",     4'he, 2'b01, 6'b011000, 4'd3,  4'h0, 4, 4'h0};
        tbl[3]  = '{"cmp_z",   4'he, 2'b00, 6'b010101, 4'd0,  4'h4, 4, 4'h4};
        tbl[4]  = '{"beq_tk",  4'h0, 2'b10, 6'b000000, 4'd0,  4'h0, 3, 4'h4};
        tbl[5]  = '{"cmp_nz",  4'he, 2'b00, 6'b010101, 4'd0,  4'h0, 4, 4'h0};
        tbl[6]  = '{"beq_nt",  4'h0, 2'b10, 6'b000000, 4'd0,  4'h0, 3, 4'h0};
        tbl[7]  = '{"addseq",  4'h0, 2'b00, 6'b001001, 4'd1,  4'hf, 4, 4'h0};
        tbl[8]  = '{"add_pc",  4'he, 2'b00, 6'b001000, 4'd15, 4'h0, 4, 4'h0};
        tbl[9]  = '{"nop",     4'he, 2'b11, 6'b000000, 4'd0,  4'h0, 2, 4'h0};
        tbl[10] = '{"orrs",    4'he, 2'b00, 6'b011001, 4'd4,  4'h8, 4, 4'h8};
        tbl[11] = '{"bmi",     4'h4, 2'b10, 6'b000000, 4'd0,  4'h0, 3, 4'h8};
        tbl[12] = '{"subs",    4'he, 2'b00, 6'b000101, 4'd5,  4'h6, 4, 4'h6};
        tbl[13] = '{"addis",   4'he, 2'b00, 6'b101001, 4'd6,  4'h1, 4, 4'h1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset enables", {state, PCWrite, IRWrite, MemWrite, RegWrite}, {4'(FETCH), 4'b0000});
        check("reset flags", dut.u_cond.flags, 4'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            run_instr(tbl[i].name, tbl[i].cc, tbl[i].op, tbl[i].f, tbl[i].rd, tbl[i].af, ncyc, plen);
            check($sformatf("%s cycles", tbl[i].name), ncyc, tbl[i].cyc);
            check($sformatf("%s flags", tbl[i].name), dut.u_cond.flags, tbl[i].fl);
        end

        // Reset landing in MEMWRITE must suppress the store and clear the flags
        Cond = 4'he; Op = 2'b01; Funct = 6'b011000; Rd = 4'd3;
        for (int n = 0; n < 6 && state != 4'(MEMWRITE); n++) begin
            @(posedge clk);
            #1;
        end
        check("reach memwrite", state, 4'(MEMWRITE));
        reset = 1'b1;
        @(negedge clk);
        check("memwrite under reset", {state, MemWrite}, {4'(MEMWRITE), 1'b0});
        @(posedge clk);
        #1;
        check("state after reset", state, 4'(FETCH));
        check("flags after reset", dut.u_cond.flags, 4'h0);
        reset = 1'b0;
        mflags = 4'h0;

        for (int k = 0; k < 300; k++) begin
            op = 2'($urandom_range(0, 3));
            f  = 6'($urandom);
            if (op == 2'b00 && !writes_model(f[4:1]) && f[4:1] != 4'b1010) f[0] = 1'b0;
            rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            run_instr($sformatf("rnd%0d", k), 4'($urandom), op, f, rd, 4'($urandom), ncyc, plen);
            check($sformatf("rnd%0d cycles", k), ncyc, plen);
            check($sformatf("rnd%0d flags", k), dut.u_cond.flags, mflags);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
